ysyx_25020081_wb_arbiter: RTL

Shares the single regfile write port between two writeback requesters: port 0 (EXU, ALU/CSR results) and port 1 (LSU, load data). Arbitrates round-robin with valid/ready handshakes, registers the winning write into a one-entry output stage that drives the regfile's `wen`/`waddr`/`wdata`, and filters writes to x0. It sits between the execute/memory units and `ysyx_25020081_regfile`. Optional read forwarding covers the one-cycle window before a staged write lands.

---
 rtl/ysyx_25020081_wb_arbiter.sv | 64 ++++++
 1 files changed

// File: rtl/ysyx_25020081_wb_arbiter.sv
// ysyx_25020081_wb_arbiter: round-robin merge of EXU/LSU writebacks into one staged regfile write port.
// Define YSYX_25020081_WB_FWD_EN to bypass the staged write onto the read ports.
module ysyx_25020081_wb_arbiter #(
   parameter int RF_ADDR_WIDTH = 5,
   parameter int DATA_WIDTH    = 32,
   parameter int CNT_WIDTH     = 32
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     req0_valid,
   output logic                     req0_ready,
   input  logic [RF_ADDR_WIDTH-1:0] req0_waddr,
   input  logic [DATA_WIDTH-1:0]    req0_wdata,
   input  logic                     req1_valid,
   output logic                     req1_ready,
   input  logic [RF_ADDR_WIDTH-1:0] req1_waddr,
   input  logic [DATA_WIDTH-1:0]    req1_wdata,
   output logic                     rf_wen,
   output logic [RF_ADDR_WIDTH-1:0] rf_waddr,
   output logic [DATA_WIDTH-1:0]    rf_wdata,
   input  logic [RF_ADDR_WIDTH-1:0] rd_raddr1,
   input  logic [RF_ADDR_WIDTH-1:0] rd_raddr2,
   input  logic [DATA_WIDTH-1:0]    rf_rdata1,
   input  logic [DATA_WIDTH-1:0]    rf_rdata2,
   output logic [DATA_WIDTH-1:0]    rd_rdata1,
   output logic [DATA_WIDTH-1:0]    rd_rdata2,
   output logic [CNT_WIDTH-1:0]     perf_wb_cnt,
   output logic [CNT_WIDTH-1:0]     perf_conflict_cnt
);
   logic                     last;
   logic                     stg_valid;
   logic [RF_ADDR_WIDTH-1:0] sel_waddr;
   // on conflict the port that did not win last time goes first
   assign req0_ready = req0_valid && (!req1_valid || last);
   assign req1_ready = req1_valid && (!req0_valid || !last);
   assign sel_waddr  = req1_ready ? req1_waddr : req0_waddr;
   assign rf_wen     = stg_valid;
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         last              <= 1'b1;
         stg_valid         <= 1'b0;
         rf_waddr          <= '0;
         rf_wdata          <= '0;
         perf_wb_cnt       <= '0;
         perf_conflict_cnt <= '0;
      end else begin
         stg_valid         <= (req0_ready || req1_ready) && (sel_waddr != '0);
         perf_wb_cnt       <= perf_wb_cnt + CNT_WIDTH'(stg_valid);
         perf_conflict_cnt <= perf_conflict_cnt + CNT_WIDTH'(req0_valid && req1_valid);
         if (req0_ready || req1_ready) begin
            last     <= req1_ready;
            rf_waddr <= sel_waddr;
            rf_wdata <= req1_ready ? req1_wdata : req0_wdata;
         end
      end
   end
`ifdef YSYX_25020081_WB_FWD_EN
   assign rd_rdata1 = (stg_valid && rd_raddr1 == rf_waddr && rd_raddr1 != '0) ? rf_wdata : rf_rdata1;
   assign rd_rdata2 = (stg_valid && rd_raddr2 == rf_waddr && rd_raddr2 != '0) ? rf_wdata : rf_rdata2;
`else
   assign rd_rdata1 = rf_rdata1;
   assign rd_rdata2 = rf_rdata2;
`endif
endmodule
